// File: rtl/flash_burst_rd.sv
// Burst read sequencer: splits {addr,len} requests into single-byte SPI engine
// transactions and streams the returned bytes through an output FIFO.
module flash_burst_rd #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LEN_W      = 16,
  parameter logic [7:0]  RD_CMD     = 8'h0B,
  parameter logic [2:0]  DUMMY_NUM  = 3'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             spi_start,
  output logic [7:0]       spi_cmd,
  output logic [23:0]      spi_addr,
  output logic [2:0]       spi_dummy_num,
  input  logic             spi_finish,
  input  logic [7:0]       spi_rdata
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [23:0]       cur_addr_r, cur_addr_s;
  logic [LEN_W-1:0]  remain_r, remain_s;
  logic              err_s, start_s, push_s, accept_s;
  logic              req_ready_r, busy_r, done_r, err_r, spi_start_r;
  logic [23:0]       spi_addr_r;

  logic [7:0]        mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  fifo_cnt_r, fifo_cnt_s;
  logic              m_valid_r, pop_s, wr_en_s;

  assign req_ready     = req_ready_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;
  assign spi_start     = spi_start_r;
  assign spi_addr      = spi_addr_r;
  assign spi_cmd       = RD_CMD;
  assign spi_dummy_num = DUMMY_NUM;
  assign m_valid       = m_valid_r;
  assign m_data        = mem_r[rd_ptr_r];

  // Sequencer next-state and per-byte transaction control
  always_comb begin
    state_s    = state_r;
    cur_addr_s = cur_addr_r;
    remain_s   = remain_r;
    err_s      = 1'b0;
    start_s    = 1'b0;
    push_s     = 1'b0;
    accept_s   = req_valid & req_ready_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          cur_addr_s = req_addr;
          remain_s   = req_len;
          // Address 0 means "no address phase" to the engine, so it is rejected
          if ((req_len == {LEN_W{1'b0}}) || (req_addr == 24'h000000)) begin
            state_s = ST_FIN;
            err_s   = 1'b1;
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (fifo_cnt_r < DEPTH_C) begin
          start_s = 1'b1;
          state_s = ST_WAIT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (spi_finish) begin
          push_s   = 1'b1;
          remain_s = remain_r - LEN_W'(1);
          if (remain_r == LEN_W'(1)) begin
            state_s = ST_FIN;
          end else if (cur_addr_r == 24'hFFFFFF) begin
            state_s = ST_FIN;
            err_s   = 1'b1;
          end else begin
            cur_addr_s = cur_addr_r + 24'd1;
            state_s    = ST_ISSUE;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cur_addr_r  <= 24'h000000;
      remain_r    <= {LEN_W{1'b0}};
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      spi_start_r <= 1'b0;
      spi_addr_r  <= 24'h000000;
    end else begin
      state_r     <= state_s;
      cur_addr_r  <= cur_addr_s;
      remain_r    <= remain_s;
      req_ready_r <= (state_s == ST_IDLE);
      busy_r      <= (state_s == ST_ISSUE) || (state_s == ST_WAIT);
      done_r      <= (state_s == ST_FIN);
      err_r       <= err_s;
      spi_start_r <= start_s;
      spi_addr_r  <= start_s ? cur_addr_r : spi_addr_r;
    end
  end

  // FIFO occupancy bookkeeping; push+pop together leaves the count unchanged
  always_comb begin
    pop_s      = m_valid_r & m_ready;
    wr_en_s    = push_s & ((fifo_cnt_r != DEPTH_C) | pop_s);
    fifo_cnt_s = fifo_cnt_r;
    if (wr_en_s && !pop_s) begin
      fifo_cnt_s = fifo_cnt_r + CNT_W'(1);
    end else if (!wr_en_s && pop_s) begin
      fifo_cnt_s = fifo_cnt_r - CNT_W'(1);
    end else begin
      fifo_cnt_s = fifo_cnt_r;
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_cnt_r <= {CNT_W{1'b0}};
      m_valid_r  <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= spi_rdata;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      fifo_cnt_r <= fifo_cnt_s;
      m_valid_r  <= (fifo_cnt_s != {CNT_W{1'b0}});
    end
  end

endmodule

// File: tb/tb_flash_burst_rd.sv
// Directed bench for flash_burst_rd with a small SPI engine responder whose
// read data is 8'hA0 plus the low address byte.
module tb_flash_burst_rd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = 24'h0;
  logic [15:0] req_len = 16'h0;
  logic        busy, done, err, m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        spi_start;
  logic [7:0]  spi_cmd;
  logic [23:0] spi_addr;
  logic [2:0]  spi_dummy_num;
  logic        spi_finish = 1'b0;
  logic [7:0]  spi_rdata = 8'h00;
  logic        inj_finish = 1'b0;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int eng_cnt = 0;
  logic [23:0] addr_q[$];
  logic [7:0]  rx_q[$];

  flash_burst_rd dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .busy(busy), .done(done), .err(err),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .spi_start(spi_start), .spi_cmd(spi_cmd), .spi_addr(spi_addr),
    .spi_dummy_num(spi_dummy_num), .spi_finish(spi_finish), .spi_rdata(spi_rdata)
  );

  always #5 clk = ~clk;

  // Engine responder: finish three cycles after a start, driven on negedge
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cnt    = 0;
      spi_finish = 1'b0;
    end else begin
      spi_finish = inj_finish;
      if (eng_cnt > 0) begin
        eng_cnt = eng_cnt - 1;
        if (eng_cnt == 0) begin
          spi_finish = 1'b1;
          spi_rdata  = spi_addr[7:0] + 8'hA0;
        end
      end else if (spi_start) begin
        eng_cnt = 3;
      end
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (spi_start) begin
      start_cnt = start_cnt + 1;
      addr_q.push_back(spi_addr);
    end
    if (m_valid && m_ready) rx_q.push_back(m_data);
    if (done) done_cnt = done_cnt + 1;
    if (err) err_cnt = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else pass_cnt++;
  endtask

  task automatic send_req(input logic [23:0] a, input logic [15:0] l);
    int n = 0;
    @(posedge clk); #1;
    req_addr = a; req_len = l; req_valid = 1'b1;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("req_ready_before_accept", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 400) begin @(negedge clk); n++; end
    check(tag, done_cnt >= target, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int sb, ab, rb, db, eb, n;
    // reset values
    idle(3);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_spi_start", spi_start, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_spi_addr", spi_addr, 24'h000000);
    check("spi_cmd", spi_cmd, 8'h0B);
    check("spi_dummy_num", spi_dummy_num, 3'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // basic 4-byte burst
    sb = start_cnt; ab = addr_q.size(); rb = rx_q.size(); db = done_cnt; eb = err_cnt;
    m_ready = 1'b1;
    send_req(24'h000100, 16'd4);
    @(negedge clk);
    check("t1_busy", busy, 1'b1);
    check("t1_req_ready_low", req_ready, 1'b0);
    wait_done(db + 1, "t1_done_timeout");
    idle(4);
    check("t1_starts", start_cnt - sb, 4);
    check("t1_addr0", addr_q[ab+0], 24'h000100);
    check("t1_addr1", addr_q[ab+1], 24'h000101);
    check("t1_addr2", addr_q[ab+2], 24'h000102);
    check("t1_addr3", addr_q[ab+3], 24'h000103);
    check("t1_rx_count", rx_q.size() - rb, 4);
    check("t1_rx0", rx_q[rb+0], 8'hA0);
    check("t1_rx1", rx_q[rb+1], 8'hA1);
    check("t1_rx2", rx_q[rb+2], 8'hA2);
    check("t1_rx3", rx_q[rb+3], 8'hA3);
    check("t1_done_once", done_cnt - db, 1);
    check("t1_no_err", err_cnt - eb, 0);
    check("t1_req_ready_back", req_ready, 1'b1);

    // 12-byte burst against an 8-entry FIFO with backpressure
    sb = start_cnt; rb = rx_q.size(); db = done_cnt; eb = err_cnt;
    m_ready = 1'b0;
    send_req(24'h000200, 16'd12);
    idle(120);
    check("t2_stall_starts", start_cnt - sb, 8);
    check("t2_stall_no_done", done_cnt - db, 0);
    check("t2_stall_busy", busy, 1'b1);
    check("t2_stall_m_valid", m_valid, 1'b1);
    @(posedge clk); #1 m_ready = 1'b1;
    wait_done(db + 1, "t2_done_timeout");
    idle(4);
    check("t2_starts", start_cnt - sb, 12);
    check("t2_rx_count", rx_q.size() - rb, 12);
    check("t2_rx0", rx_q[rb+0], 8'hA0);
    check("t2_rx7", rx_q[rb+7], 8'hA7);
    check("t2_rx8", rx_q[rb+8], 8'hA8);
    check("t2_rx11", rx_q[rb+11], 8'hAB);
    check("t2_no_err", err_cnt - eb, 0);

    // truncation at top of address space
    sb = start_cnt; ab = addr_q.size(); rb = rx_q.size(); db = done_cnt; eb = err_cnt;
    send_req(24'hFFFFFE, 16'd5);
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    check("t3_done_seen", done, 1'b1);
    check("t3_err_with_done", err, 1'b1);
    idle(4);
    check("t3_starts", start_cnt - sb, 2);
    check("t3_addr0", addr_q[ab+0], 24'hFFFFFE);
    check("t3_addr1", addr_q[ab+1], 24'hFFFFFF);
    check("t3_rx_count", rx_q.size() - rb, 2);
    check("t3_rx0", rx_q[rb+0], 8'h9E);
    check("t3_rx1", rx_q[rb+1], 8'h9F);
    check("t3_done_once", done_cnt - db, 1);

    // zero length, then address zero
    sb = start_cnt;
    send_req(24'h000300, 16'd0);
    @(negedge clk);
    check("t4a_done", done, 1'b1);
    check("t4a_err", err, 1'b1);
    check("t4a_busy", busy, 1'b0);
    @(negedge clk);
    check("t4a_done_pulse", done, 1'b0);
    check("t4a_req_ready", req_ready, 1'b1);
    send_req(24'h000000, 16'd3);
    @(negedge clk);
    check("t4b_done", done, 1'b1);
    check("t4b_err", err, 1'b1);
    idle(6);
    check("t4_no_starts", start_cnt - sb, 0);

    // stray finish while idle
    rb = rx_q.size();
    @(posedge clk); #1 inj_finish = 1'b1; spi_rdata = 8'h5A;
    @(posedge clk); #1 inj_finish = 1'b0;
    idle(3);
    check("t5_m_valid", m_valid, 1'b0);
    check("t5_no_rx", rx_q.size() - rb, 0);

    // async reset in WAIT after two of six bytes
    sb = start_cnt; rb = rx_q.size(); db = done_cnt;
    m_ready = 1'b0;
    send_req(24'h000400, 16'd6);
    n = 0;
    while ((start_cnt - sb) < 3 && n < 200) begin @(negedge clk); n++; end
    check("t6_third_start", start_cnt - sb, 3);
    check("t6_two_bytes_held", m_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_spi_start", spi_start, 1'b0);
    check("t6_rst_m_valid", m_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_req_ready", req_ready, 1'b1);
    check("t6_rst_spi_addr", spi_addr, 24'h000000);
    idle(2);
    @(posedge clk); #1 rst_n = 1'b1;
    m_ready = 1'b1;
    sb = start_cnt; ab = addr_q.size(); rb = rx_q.size(); db = done_cnt; eb = err_cnt;
    send_req(24'h000010, 16'd1);
    wait_done(db + 1, "t6_done_timeout");
    idle(4);
    check("t6_starts", start_cnt - sb, 1);
    check("t6_addr", addr_q[ab], 24'h000010);
    check("t6_rx_count", rx_q.size() - rb, 1);
    check("t6_rx0", rx_q[rb], 8'hB0);
    check("t6_no_err", err_cnt - eb, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
